boot_load_sequencer: RTL
========================

# boot_load_sequencer

Host-facing sequencer that owns the pipelined core's debug/init port and its run control. It accepts a word stream from a host link and decodes headers. It loads 64-bit beats into instruction or data memory through the datapath's debug write path, then releases the core for a bounded run. When the run ends it parks the core and returns a status word. It sits between the host link and the `Datapath` inputs `enable_debug`, `reset`, `DebugAddress/DebugData1/DebugData2` and `debug_inst_addr/debug_inst_data1/debug_inst_data2`.

## Interface
- DM_ADDRESS, 9, byte-address width of both memories
- DATA_W, 32, word width
- CYC_W, 16, run-cycle budget/counter width
- HALT_ADDR, 9'h1FC, data-memory byte address whose store ends a run
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- host_valid  in  1  host word valid
- host_ready  out  1  sequencer accepts host word
- host_data  in  DATA_W  header or payload word
- resp_valid  out  1  status word valid
- resp_ready  in  1  host accepts status word
- resp_data  out  DATA_W  status word
- dp_wr  in  1  datapath EX/MEM store strobe (`wr`)
- dp_addr  in  DM_ADDRESS  datapath store address (`addr`)
- dbg_en  out  1  drives `enable_debug`
- core_rst  out  1  ORed with system reset into datapath `reset`
- im_addr  out  DM_ADDRESS  instruction memory debug address
- im_data1, im_data2  out  DATA_W  instruction memory debug data
- dm_addr  out  DM_ADDRESS  data memory debug address
- dm_data1, dm_data2  out  DATA_W  data memory debug data

## Operation
- Handshakes: a transfer occurs on a cycle with valid&&ready. resp_data is stable while resp_valid=1 and resp_ready=0.
- Header word fields: [31:30] op, with 00=load IMEM, 01=load DMEM, 10=run, 11=invalid. [24:16] base byte address. [15:0] N = beat count (load) or cycle budget (run).
- Load: 2N payload words follow the header. The first word of each pair is data1 and the second is data2. Beat k is written at base+8k; the address wraps mod 2^DM_ADDRESS.
- Hold registers: separate register sets for im_* and dm_*. Only the targeted set updates on a beat; the other set keeps its last value.
  - dbg_en writes both memories. The non-targeted memory therefore rewrites its last-written beat, which is idempotent because the core is parked.
  - After reset both sets are address 0, data 0. The first beat of either kind writes zeros at address 0 of the other memory.
- States:
  - IDLE: host_ready=1. On header, op 00/01 with N>0 goes to LW1; with N=0 it goes to RESP. Op 10 with N>0 goes to RUN; with N=0 it goes to RESP (timeout, cycles 0). Op 11 goes to RESP.
  - LW1: host_ready=1. Captures data1, then goes to LW2.
  - LW2: host_ready=1. Captures data2 into the hold set, with the address loaded from the beat pointer. Goes to WR.
  - WR: dbg_en=1 for exactly one cycle. Beat pointer increments by 8 and the beat counter increments. If beats==N go to RESP, else go to LW1.
  - RUN: core_rst=0, dbg_en=0, host_ready=0. The cycle counter increments every RUN cycle; the first cycle counts as 1.
    - dp_wr&&dp_addr==HALT_ADDR means halted.
    - Otherwise, counter==N means timeout.
    - Both in the same cycle: halt wins. On exit, core_rst rises the next cycle.
  - RESP: resp_valid=1, host_ready=0. Goes to IDLE on resp_ready.
- resp_data: [31:30] status, with 00=load done, 01=halted, 10=timeout, 11=bad op. [29:16]=0. [15:0] = beats written (load), cycles executed (run), or 0 (bad op).
- core_rst=1 in every state except RUN.
- Payload words arriving in IDLE are headers by definition; there is no resynchronisation.

## Timing
- Reset values:
  - state IDLE, dbg_en=0, core_rst=1, host_ready=0 during reset (1 in IDLE from the cycle after), resp_valid=0, resp_data=0.
  - All im_*/dm_* are 0, all counters are 0.
- All outputs are registered except host_ready and resp_valid, which decode the current state.
- Load beat cost: 3 cycles minimum (LW1, LW2, WR) with host_valid held high. resp_valid appears the cycle after the last WR.
- Run: core_rst falls on the first RUN cycle.
  - A halt store sampled in RUN cycle c gives cycles=c, and resp_valid is asserted in cycle c+1.
  - A timeout of budget N asserts resp_valid after exactly N RUN cycles.
- Reset asserted in any state, including mid-beat or mid-run, returns to IDLE the next cycle. Partial beats are discarded and core_rst=1.
- Cycle counter width is CYC_W. It cannot overflow because the budget is ≤2^CYC_W−1.

## Test plan
- Load IMEM base 0, N=2, words A0,A1,B0,B1: dbg_en pulses twice. im_addr 0 then 8 with data (A0,A1),(B0,B1). dm_* stay 0. resp=0x0000_0002.
- Load DMEM base 0x1F8, N=2: second beat writes at dm_addr 0x000 (wrap). im_* hold the prior values. resp status 00, count 2.
- Run budget 100, store to 0x1FC after 37 RUN cycles: core_rst low for 37 cycles, resp=0x4000_0025. A coincident dp_wr at cycle 100 still reports halt.
- Run budget 5 with no halt: resp=0x8000_0005. Budget 0: resp=0x8000_0000 and core_rst never falls.
- Header op 11: resp=0xC000_0000. Assert reset during LW2 and during RUN: next cycle IDLE, core_rst=1, no dbg_en pulse.
- Hold resp_ready=0 for 10 cycles: resp_data stable, host_ready=0, with host_valid pending and not consumed.

Source files
------------

// File: rtl/boot_load_sequencer.sv
// rtl/boot_load_sequencer.sv - host-driven memory loader and bounded run controller for the datapath
module boot_load_sequencer #(
    parameter int                    DM_ADDRESS = 9,
    parameter int                    DATA_W     = 32,
    parameter int                    CYC_W      = 16,
    parameter logic [DM_ADDRESS-1:0] HALT_ADDR  = 9'h1FC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [DATA_W-1:0]     host_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    input  logic                  dp_wr,
    input  logic [DM_ADDRESS-1:0] dp_addr,
    output logic                  dbg_en,
    output logic                  core_rst,
    output logic [DM_ADDRESS-1:0] im_addr,
    output logic [DATA_W-1:0]     im_data1,
    output logic [DATA_W-1:0]     im_data2,
    output logic [DM_ADDRESS-1:0] dm_addr,
    output logic [DATA_W-1:0]     dm_data1,
    output logic [DATA_W-1:0]     dm_data2
);

    typedef enum logic [2:0] {
        S_IDLE, S_LW1, S_LW2, S_WR, S_RUN, S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [15:0]           n_q, n_d;
    logic [15:0]           beats_q, beats_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [DM_ADDRESS-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0]     d1_q, d1_d;
    logic [DM_ADDRESS-1:0] im_addr_q, im_addr_d, dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]     im_data1_q, im_data1_d, im_data2_q, im_data2_d;
    logic [DATA_W-1:0]     dm_data1_q, dm_data1_d, dm_data2_q, dm_data2_d;
    logic                  dbg_en_q, dbg_en_d;
    logic                  core_rst_q, core_rst_d;
    logic [DATA_W-1:0]     resp_data_q, resp_data_d;

    logic [CYC_W-1:0]      cyc_next;
    logic [15:0]           beats_next;
    logic                  halt_hit;

    // Next-state, beat capture and status composition
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        n_d         = n_q;
        beats_d     = beats_q;
        cyc_d       = cyc_q;
        ptr_d       = ptr_q;
        d1_d        = d1_q;
        im_addr_d   = im_addr_q;
        im_data1_d  = im_data1_q;
        im_data2_d  = im_data2_q;
        dm_addr_d   = dm_addr_q;
        dm_data1_d  = dm_data1_q;
        dm_data2_d  = dm_data2_q;
        resp_data_d = resp_data_q;
        dbg_en_d    = 1'b0;
        core_rst_d  = 1'b1;
        cyc_next    = cyc_q + CYC_W'(1);
        beats_next  = beats_q + 16'd1;
        halt_hit    = dp_wr && (dp_addr == HALT_ADDR);

        case (state_q)
            S_IDLE: begin
                if (host_valid) begin
                    op_d    = host_data[31:30];
                    n_d     = host_data[15:0];
                    ptr_d   = host_data[16 +: DM_ADDRESS];
                    beats_d = '0;
                    cyc_d   = '0;
                    resp_data_d = '0;
                    case (host_data[31:30])
                        2'b00, 2'b01: begin
                            state_d = (host_data[15:0] != 16'd0) ? S_LW1 : S_RESP;
                        end
                        2'b10: begin
                            if (host_data[15:0] != 16'd0) begin
                                state_d    = S_RUN;
                                core_rst_d = 1'b0;
                            end else begin
                                state_d            = S_RESP;
                                resp_data_d[31:30] = 2'b10;
                            end
                        end
                        default: begin
                            state_d            = S_RESP;
                            resp_data_d[31:30] = 2'b11;
                        end
                    endcase
                end
            end
            S_LW1: begin
                if (host_valid) begin
                    d1_d    = host_data;
                    state_d = S_LW2;
                end
            end
            S_LW2: begin
                // Only the targeted hold set moves; the other keeps its last beat
                if (host_valid) begin
                    if (op_q == 2'b00) begin
                        im_addr_d  = ptr_q;
                        im_data1_d = d1_q;
                        im_data2_d = host_data;
                    end else begin
                        dm_addr_d  = ptr_q;
                        dm_data1_d = d1_q;
                        dm_data2_d = host_data;
                    end
                    dbg_en_d = 1'b1;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                ptr_d   = ptr_q + DM_ADDRESS'(8);
                beats_d = beats_next;
                if (beats_next == n_q) begin
                    state_d            = S_RESP;
                    resp_data_d        = '0;
                    resp_data_d[15:0]  = beats_next;
                end else begin
                    state_d = S_LW1;
                end
            end
            S_RUN: begin
                cyc_d = cyc_next;
                if (halt_hit) begin
                    state_d            = S_RESP;
                    resp_data_d        = '0;
                    resp_data_d[31:30] = 2'b01;
                    resp_data_d[15:0]  = 16'(cyc_next);
                end else if (cyc_next == CYC_W'(n_q)) begin
                    state_d            = S_RESP;
                    resp_data_d        = '0;
                    resp_data_d[31:30] = 2'b10;
                    resp_data_d[15:0]  = 16'(cyc_next);
                end else begin
                    core_rst_d = 1'b0;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            n_q         <= '0;
            beats_q     <= '0;
            cyc_q       <= '0;
            ptr_q       <= '0;
            d1_q        <= '0;
            im_addr_q   <= '0;
            im_data1_q  <= '0;
            im_data2_q  <= '0;
            dm_addr_q   <= '0;
            dm_data1_q  <= '0;
            dm_data2_q  <= '0;
            dbg_en_q    <= 1'b0;
            core_rst_q  <= 1'b1;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            n_q         <= n_d;
            beats_q     <= beats_d;
            cyc_q       <= cyc_d;
            ptr_q       <= ptr_d;
            d1_q        <= d1_d;
            im_addr_q   <= im_addr_d;
            im_data1_q  <= im_data1_d;
            im_data2_q  <= im_data2_d;
            dm_addr_q   <= dm_addr_d;
            dm_data1_q  <= dm_data1_d;
            dm_data2_q  <= dm_data2_d;
            dbg_en_q    <= dbg_en_d;
            core_rst_q  <= core_rst_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Handshake strobes decode the current state and are held off during reset
    always_comb begin
        host_ready = !reset && (state_q == S_IDLE || state_q == S_LW1 || state_q == S_LW2);
        resp_valid = !reset && (state_q == S_RESP);
    end

    assign resp_data = resp_data_q;
    assign dbg_en    = dbg_en_q;
    assign core_rst  = core_rst_q;
    assign im_addr   = im_addr_q;
    assign im_data1  = im_data1_q;
    assign im_data2  = im_data2_q;
    assign dm_addr   = dm_addr_q;
    assign dm_data1  = dm_data1_q;
    assign dm_data2  = dm_data2_q;

endmodule
